// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register file and its read ports.
package regfile_pkg;

    localparam int WORDSIZE_DEF = 64;
    localparam int SIZE_DEF     = 32;
    localparam int ADDR_W       = 5;

    typedef logic [WORDSIZE_DEF-1:0] word_t;
    typedef logic [ADDR_W-1:0]       reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// Combinational index-to-word mux for one read port.
// Honors REGFILE_ZERO_REG_EN (register 0 always reads zero).
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WORDSIZE = WORDSIZE_DEF,
    parameter int SIZE     = SIZE_DEF
) (
    input  logic [WORDSIZE-1:0] regs [SIZE],
    input  reg_addr_t           addr,
    output logic [WORDSIZE-1:0] data
);

    always_comb begin
        data = '0;
        // Addresses beyond the populated range read as zero.
        if (int'(addr) < SIZE) begin
            data = regs[addr];
        end
`ifdef REGFILE_ZERO_REG_EN
        if (addr == '0) begin
            data = '0;
        end
`endif
    end

endmodule

// File: rtl/register_file.sv
// Register file: one synchronous write port, two asynchronous read ports.
// Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module register_file
    import regfile_pkg::*;
#(
    parameter int WORDSIZE = WORDSIZE_DEF,
    parameter int SIZE     = SIZE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                write_en,
    input  reg_addr_t           write_addr,
    input  logic [WORDSIZE-1:0] write_data,
    input  reg_addr_t           addr_a,
    output logic [WORDSIZE-1:0] data_a,
    input  reg_addr_t           addr_b,
    output logic [WORDSIZE-1:0] data_b
);

    logic [WORDSIZE-1:0] regs [SIZE];
    logic                write_hit;

    always_comb begin
        write_hit = write_en && (int'(write_addr) < SIZE);
`ifdef REGFILE_ZERO_REG_EN
        if (write_addr == '0) begin
            write_hit = 1'b0;
        end
`endif
    end

    // Storage is cleared by reset so no register ever holds X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[write_addr] <= write_data;
        end
    end

    regfile_read_port #(
        .WORDSIZE (WORDSIZE),
        .SIZE     (SIZE)
    ) u_port_a (
        .regs (regs),
        .addr (addr_a),
        .data (data_a)
    );

    regfile_read_port #(
        .WORDSIZE (WORDSIZE),
        .SIZE     (SIZE)
    ) u_port_b (
        .regs (regs),
        .addr (addr_b),
        .data (data_b)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed scoreboard bench for register_file.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [63:0] write_data;
    logic [4:0]  addr_a;
    logic [63:0] data_a;
    logic [4:0]  addr_b;
    logic [63:0] data_b;

    typedef struct {
        bit          chk_a;
        logic [63:0] exp_a;
        bit          chk_b;
        logic [63:0] exp_b;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    event  pushed;
    int    checks = 0;
    int    errors = 0;

    register_file dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .addr_a     (addr_a),
        .data_a     (data_a),
        .addr_b     (addr_b),
        .data_b     (data_b)
    );

    always #5 clk = ~clk;

    task automatic expect_rd(input string name, input bit ca, input logic [63:0] ea,
                             input bit cb, input logic [63:0] eb);
        exp_t e;
        e.chk_a = ca;
        e.exp_a = ea;
        e.chk_b = cb;
        e.exp_b = eb;
        exp_q.push_back(e);
        name_q.push_back(name);
        ->pushed;
        #1;
    endtask

    // Monitor: samples the read ports whenever an expectation is queued.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(pushed);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (e.chk_a) begin
                    checks++;
                    if (data_a !== e.exp_a) begin
                        errors++;
                        $display("FAIL %s data_a: got %h expected %h", n, data_a, e.exp_a);
                    end
                end
                if (e.chk_b) begin
                    checks++;
                    if (data_b !== e.exp_b) begin
                        errors++;
                        $display("FAIL %s data_b: got %h expected %h", n, data_b, e.exp_b);
                    end
                end
            end
        end
    end

    localparam logic [63:0] V13  = 64'h0000_0000_0000_aabb;
    localparam logic [63:0] V4   = 64'h0000_0000_e45f_b21f;
`ifdef REGFILE_ZERO_REG_EN
    localparam logic [63:0] V0   = 64'h0;
`else
    localparam logic [63:0] V0   = 64'h1234;
`endif

    initial begin
        rst_n      = 1'b0;
        write_en   = 1'b0;
        write_addr = '0;
        write_data = '0;
        addr_a     = '0;
        addr_b     = '0;
        #2;
        expect_rd("reset_held", 1, 64'h0, 1, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write 13, read 13 and 6.
        @(negedge clk);
        write_en   = 1'b1;
        write_addr = 5'd13;
        write_data = V13;
        addr_a     = 5'd13;
        addr_b     = 5'd6;
        #1;
        expect_rd("t1_before_edge", 1, 64'h0, 1, 64'h0);
        @(posedge clk);
        #1;
        expect_rd("t1_after_edge", 1, V13, 1, 64'h0);

        // Address change reflects without a clock edge.
        addr_b = 5'd4;
        #1;
        expect_rd("t2_addr_change", 1, V13, 1, 64'h0);

        @(negedge clk);
        write_addr = 5'd4;
        write_data = V4;
        #1;
        expect_rd("t3_before_edge", 0, 64'h0, 1, 64'h0);
        @(posedge clk);
        #1;
        expect_rd("t3_after_edge", 1, V13, 1, V4);

        @(negedge clk);
        write_en   = 1'b0;
        write_addr = 5'd13;
        write_data = '1;
        repeat (3) @(posedge clk);
        #1;
        expect_rd("t4_write_en_low", 1, V13, 1, V4);

        // Mid-cycle write inputs do not bypass to reads and are not stored if withdrawn.
        @(negedge clk);
        write_en   = 1'b1;
        write_data = 64'h1111_2222_3333_4444;
        #1;
        expect_rd("no_bypass", 1, V13, 0, 64'h0);
        write_en = 1'b0;
        @(posedge clk);
        #1;
        expect_rd("withdrawn_write", 1, V13, 0, 64'h0);

        addr_a = 5'd4;
        #1;
        expect_rd("same_addr_both", 1, V4, 1, V4);
        addr_a = 5'd13;

        // Async reset between edges, also dominating a coincident write.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_rd("t5_reset_immediate", 1, 64'h0, 1, 64'h0);
        write_en   = 1'b1;
        write_addr = 5'd13;
        write_data = 64'h5555_5555_5555_5555;
        @(posedge clk);
        #1;
        expect_rd("reset_dominates_write", 1, 64'h0, 0, 64'h0);
        @(negedge clk);
        write_en = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        expect_rd("t5_after_release", 1, 64'h0, 1, 64'h0);

        // Writes resume after reset.
        @(negedge clk);
        write_en   = 1'b1;
        write_addr = 5'd31;
        write_data = 64'hdead_beef_cafe_f00d;
        addr_b     = 5'd31;
        @(posedge clk);
        #1;
        expect_rd("resume_write_31", 1, 64'h0, 1, 64'hdead_beef_cafe_f00d);

        @(negedge clk);
        write_addr = 5'd0;
        write_data = 64'h1234;
        addr_a     = 5'd0;
        addr_b     = 5'd0;
        @(posedge clk);
        #1;
        expect_rd("t6_addr0", 1, V0, 1, V0);
        @(negedge clk);
        write_en = 1'b0;
        addr_b   = 5'd31;
        #1;
        expect_rd("addr31_hold", 1, V0, 1, 64'hdead_beef_cafe_f00d);

        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL timeout: simulation did not complete within 5000 time units");
        $fatal(1);
    end

endmodule
